core_ctrl: RTL and testbench

CORE_CTRL -- requirements
Module: core_ctrl

---
 rtl/core_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_core_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/core_ctrl.sv
// core_ctrl: sequences one weight-load / execute / drain / psum-write (/ SFP) pass of the core.
// Latency: inst/busy/done are registered; the first WLOAD word appears the cycle after start is accepted.
// Backpressure: DRAIN waits on ofifo_valid; each OREAD write is issued only while ofifo_valid=1 (index held otherwise).
//
// Ports: clk, reset (async, active-low); start pulse with w_base/x_base/n_act/p_base operands latched on
// acceptance; ofifo_valid from the core output FIFO; inst = 34-bit instruction word; busy; done pulse.
// Optional feature: define CORE_CTRL_SFP_EN to add the SFP pass after OREAD (inst[33] otherwise tied 0).
module core_ctrl #(
    parameter int row = 8,
    parameter int col = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [10:0] w_base,
    input  logic [10:0] x_base,
    input  logic [10:0] n_act,
    input  logic [10:0] p_base,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic        busy,
    output logic        done
);

    // All enables inactive: both SRAM CEN/WEN pairs high.
    localparam logic [33:0] IDLE_W = 34'h1_800C_0000;
    localparam logic [10:0] ROW_L  = 11'(row);
    localparam logic [10:0] COL_M1 = 11'(col - 1);
`ifdef CORE_CTRL_SFP_EN
    localparam logic [10:0] COL_L  = 11'(col);
`endif

`ifdef CORE_CTRL_SFP_EN
    typedef enum logic [2:0] {IDLE, WLOAD, EXEC, DRAIN, OREAD, DONE, SFP} state_t;
`else
    typedef enum logic [2:0] {IDLE, WLOAD, EXEC, DRAIN, OREAD, DONE} state_t;
`endif

    state_t      state_q, state_d;
    logic [10:0] i_q, i_d;
    logic [10:0] wb_q, wb_d, xb_q, xb_d, na_q, na_d, pb_q, pb_d;
    logic [33:0] inst_q, inst_d;
    logic        busy_q, done_q;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        wb_d    = wb_q;
        xb_d    = xb_q;
        na_d    = na_q;
        pb_d    = pb_q;
        inst_d  = IDLE_W;
        // L0 write/read strobes trail the xmem read by one cycle (SRAM read latency).
        inst_d[3:2] = {2{inst_q[0]}};
        inst_d[5:4] = {2{inst_q[1]}};
`ifdef CORE_CTRL_SFP_EN
        // SFP valid trails each psum read (CEN low, WEN high) by one cycle.
        inst_d[33] = ~inst_q[32] & inst_q[31];
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    wb_d        = w_base;
                    xb_d        = x_base;
                    na_d        = n_act;
                    pb_d        = p_base;
                    state_d     = WLOAD;
                    i_d         = '0;
                    inst_d[19]  = 1'b0;
                    inst_d[17:7] = w_base;
                    inst_d[0]   = 1'b1;
                end
            end
            WLOAD: begin
                if (i_q == ROW_L) begin
                    // Lag cycle done: skip EXEC entirely when there are no activations.
                    i_d = '0;
                    if (na_q == 11'd0) begin
                        state_d = DRAIN;
                    end else begin
                        state_d      = EXEC;
                        inst_d[19]   = 1'b0;
                        inst_d[17:7] = xb_q;
                        inst_d[1]    = 1'b1;
                    end
                end else begin
                    i_d = i_q + 11'd1;
                    if (i_d != ROW_L) begin
                        inst_d[19]   = 1'b0;
                        inst_d[17:7] = wb_q + i_d;
                        inst_d[0]    = 1'b1;
                    end
                end
            end
            EXEC: begin
                if (i_q == na_q) begin
                    state_d = DRAIN;
                    i_d     = '0;
                end else begin
                    i_d = i_q + 11'd1;
                    if (i_d != na_q) begin
                        inst_d[19]   = 1'b0;
                        inst_d[17:7] = xb_q + i_d;
                        inst_d[1]    = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (ofifo_valid) begin
                    state_d       = OREAD;
                    i_d           = '0;
                    inst_d[6]     = 1'b1;
                    inst_d[32]    = 1'b0;
                    inst_d[31]    = 1'b0;
                    inst_d[30:20] = pb_q;
                end
            end
            OREAD: begin
                // i_q is the index written this cycle when inst_q[6] is set, else the pending index.
                if (inst_q[6] && (i_q == COL_M1)) begin
                    i_d = '0;
`ifdef CORE_CTRL_SFP_EN
                    state_d       = SFP;
                    inst_d[32]    = 1'b0;
                    inst_d[30:20] = pb_q;
`else
                    state_d = DONE;
`endif
                end else begin
                    if (inst_q[6]) begin
                        i_d = i_q + 11'd1;
                    end
                    if (ofifo_valid) begin
                        inst_d[6]     = 1'b1;
                        inst_d[32]    = 1'b0;
                        inst_d[31]    = 1'b0;
                        inst_d[30:20] = pb_q + i_d;
                    end
                end
            end
`ifdef CORE_CTRL_SFP_EN
            SFP: begin
                if (i_q == COL_L) begin
                    state_d = DONE;
                    i_d     = '0;
                end else begin
                    i_d = i_q + 11'd1;
                    if (i_d != COL_L) begin
                        inst_d[32]    = 1'b0;
                        inst_d[30:20] = pb_q + i_d;
                    end
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
                i_d     = '0;
            end
            default: begin
                state_d = IDLE;
                i_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            wb_q    <= '0;
            xb_q    <= '0;
            na_q    <= '0;
            pb_q    <= '0;
            inst_q  <= IDLE_W;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            wb_q    <= wb_d;
            xb_q    <= xb_d;
            na_q    <= na_d;
            pb_q    <= pb_d;
            inst_q  <= inst_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    assign inst = inst_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_core_ctrl.sv
module tb_core_ctrl;
    localparam int ROW = 8;
    localparam int COL = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] w_base, x_base, n_act, p_base;
    logic        ofifo_valid;
    logic [33:0] inst;
    logic        busy, done;

    typedef struct packed {
        logic [33:0] inst;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   done_cycle;
    int   exec_cnt;
    int   oread_cnt;

    core_ctrl #(.row(ROW), .col(COL)) dut (
        .clk(clk), .reset(reset), .start(start),
        .w_base(w_base), .x_base(x_base), .n_act(n_act), .p_base(p_base),
        .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    function automatic logic [33:0] idle_w();
        logic [33:0] w;
        w = '0;
        w[32] = 1'b1; w[31] = 1'b1; w[19] = 1'b1; w[18] = 1'b1;
        return w;
    endfunction

    function automatic void push(logic [33:0] w, logic b, logic d);
        exp_t e;
        e.inst = w; e.busy = b; e.done = d;
        exp_q.push_back(e);
    endfunction

    // Expected per-cycle stream of one pass, starting the cycle after start acceptance.
    function automatic void build(logic [10:0] wb, logic [10:0] xb, logic [10:0] na,
                                  logic [10:0] pb, int dw, int sa, int sl);
        logic [33:0] w;
        for (int c = 0; c <= ROW; c++) begin
            w = idle_w();
            if (c < ROW) begin w[19] = 1'b0; w[17:7] = wb + 11'(c); w[0] = 1'b1; end
            if (c > 0)   begin w[2] = 1'b1; w[3] = 1'b1; end
            push(w, 1'b1, 1'b0);
        end
        if (na != 11'd0) begin
            for (int c = 0; c <= int'(na); c++) begin
                w = idle_w();
                if (c < int'(na)) begin w[19] = 1'b0; w[17:7] = xb + 11'(c); w[1] = 1'b1; end
                if (c > 0)        begin w[5] = 1'b1; w[4] = 1'b1; end
                push(w, 1'b1, 1'b0);
            end
        end
        for (int c = 0; c <= dw; c++) push(idle_w(), 1'b1, 1'b0);
        for (int i = 0; i < COL; i++) begin
            if (i == sa) for (int s = 0; s < sl; s++) push(idle_w(), 1'b1, 1'b0);
            w = idle_w();
            w[6] = 1'b1; w[32] = 1'b0; w[31] = 1'b0; w[30:20] = pb + 11'(i);
            push(w, 1'b1, 1'b0);
        end
`ifdef CORE_CTRL_SFP_EN
        for (int c = 0; c <= COL; c++) begin
            w = idle_w();
            if (c < COL) begin w[32] = 1'b0; w[30:20] = pb + 11'(c); end
            if (c > 0)   w[33] = 1'b1;
            push(w, 1'b1, 1'b0);
        end
`endif
        push(idle_w(), 1'b1, 1'b1);
        push(idle_w(), 1'b0, 1'b0);
    endfunction

    // Must be called at a negedge with the DUT idle. abort_k>0 pulls reset after cycle abort_k.
    task automatic run_pass(input logic [10:0] wb, input logic [10:0] xb, input logic [10:0] na,
                            input logic [10:0] pb, input int dw, input int sa, input int sl,
                            input int spur_k, input int abort_k);
        int   kd, k0, k;
        exp_t e;
        build(wb, xb, na, pb, dw, sa, sl);
        kd = 1 + (ROW + 1) + ((na != 11'd0) ? int'(na) + 1 : 0);
        k0 = kd + dw + 1;
        w_base = wb; x_base = xb; n_act = na; p_base = pb;
        ofifo_valid = 1'b1;
        start = 1'b1;
        done_cycle = 0; exec_cnt = 0; oread_cnt = 0; k = 0;
        @(posedge clk);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            e = exp_q.pop_front();
            vectors++;
            if ({inst, busy, done} !== e) begin
                miscompares++;
                $display("FAIL cycle_%0d: inst=%h busy=%b done=%b, required inst=%h busy=%b done=%b",
                         k, inst, busy, done, e.inst, e.busy, e.done);
            end
            if (inst[1] === 1'b1) exec_cnt++;
            if (inst[6] === 1'b1) oread_cnt++;
            if (done === 1'b1 && done_cycle == 0) done_cycle = k;
            if (k == abort_k) begin
                reset = 1'b0;
                #1;
                vectors++;
                if ({inst, busy, done} !== {idle_w(), 1'b0, 1'b0}) begin
                    miscompares++;
                    $display("FAIL reset_mid_pass: inst=%h busy=%b done=%b, required inst=%h busy=0 done=0",
                             inst, busy, done, idle_w());
                end
                exp_q.delete();
                @(negedge clk);
                reset = 1'b1;
                return;
            end
            if (k == spur_k) begin
                start = 1'b1;
                w_base = 11'h7ff; x_base = 11'h555; n_act = 11'd1; p_base = 11'h0;
            end
            ofifo_valid = !((k >= kd && k < kd + dw) || (k >= k0 + sa - 1 && k < k0 + sa - 1 + sl));
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; ofifo_valid = 1'b1;
        w_base = '0; x_base = '0; n_act = '0; p_base = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if (inst !== idle_w()) begin
            miscompares++;
            $display("FAIL reset_inst: got %h, required %h", inst, idle_w());
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b, required 0", busy);
        end
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_done: got %b, required 0", done);
        end
        reset = 1'b1;
    endtask

    task automatic test_wload_base16();
        run_pass(11'd16, 11'd100, 11'd3, 11'd200, 0, 0, 0, 0, 0);
        vectors++;
        if (exec_cnt != 3) begin
            miscompares++;
            $display("FAIL wload_exec_count: got %0d, required 3", exec_cnt);
        end
    endtask

    task automatic test_nact_zero();
        run_pass(11'd40, 11'd500, 11'd0, 11'd10, 0, 0, 0, 0, 0);
        vectors++;
        if (exec_cnt != 0) begin
            miscompares++;
            $display("FAIL nact_zero_exec_count: got %0d, required 0", exec_cnt);
        end
    endtask

    task automatic test_xaddr_wrap();
        run_pass(11'd2044, 11'd2045, 11'd4, 11'd0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_ofifo_stall();
        run_pass(11'd1, 11'd2, 11'd2, 11'd2044, 2, 3, 3, 0, 0);
        vectors++;
        if (oread_cnt != COL) begin
            miscompares++;
            $display("FAIL stall_oread_count: got %0d, required %0d", oread_cnt, COL);
        end
    endtask

    task automatic test_full_pass();
        int exp_done;
`ifdef CORE_CTRL_SFP_EN
        exp_done = 9 + 11 + 1 + 8 + 9 + 1;
`else
        exp_done = 9 + 11 + 1 + 8 + 1;
`endif
        run_pass(11'd0, 11'd64, 11'd10, 11'd128, 0, 0, 0, 20, 0);
        vectors++;
        if (done_cycle != exp_done) begin
            miscompares++;
            $display("FAIL full_pass_done_cycle: got %0d, required %0d", done_cycle, exp_done);
        end
    endtask

    task automatic test_reset_mid_exec();
        run_pass(11'd16, 11'd40, 11'd10, 11'd300, 0, 0, 0, 0, 1 + (ROW + 1) + 5);
        run_pass(11'd16, 11'd40, 11'd10, 11'd300, 0, 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        run_pass(11'd7, 11'd8, 11'd1, 11'd9, 0, 0, 0, 0, 0);
        run_pass(11'd300, 11'd301, 11'd2, 11'd302, 1, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_wload_base16();
        test_nact_zero();
        test_xaddr_wrap();
        test_ofifo_stall();
        test_full_pass();
        test_reset_mid_exec();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
